usb_fs_out_pe_mc: RTL and testbench
===================================

USB_FS_OUT_PE_MC -- requirements
Module: usb_fs_out_pe_mc

Interface
REQ-001 Parameter NumOutEps, default 12: implemented OUT/SETUP endpoints, legal 1..16.
REQ-002 Parameter MaxOutPktSizeByte, default 64: per-transfer payload limit, power of two, 8..64; PktW = log2(MaxOutPktSizeByte).
REQ-003 Parameter RxTimeoutCycles, default 80: clk_48mhz_i cycles allowed from token end to DATA start, legal 16..255.
REQ-004 clk_48mhz_i  in  1  sole clock; all flops on rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 link_reset_i  in  1  bus reset; same effect as rst_i on state, toggles, counters.
REQ-007 dev_addr_i  in  7  device address.
REQ-008 rx_pkt_start_i, rx_pkt_end_i, rx_pkt_valid_i  in  1 each  packet strobes; valid qualifies end.
REQ-009 rx_pid_i  in  4; rx_addr_i  in  7; rx_endp_i  in  4  decoded token fields.
REQ-010 rx_data_put_i  in  1; rx_data_i  in  8  payload byte strobe and data.
REQ-011 out_ep_enable_i, out_ep_full_i, out_ep_stall_i, out_ep_iso_i, data_toggle_clear_i, data_toggle_set_i  in  NumOutEps each  per-EP controls.
REQ-012 out_ep_current_o  out  4; out_ep_data_put_o  out  1; out_ep_put_addr_o  out  PktW; out_ep_data_o  out  8  write port.
REQ-013 out_ep_newpkt_o, out_ep_acked_o, out_ep_rollback_o  out  1 each  transfer status pulses.
REQ-014 out_ep_setup_o  out  NumOutEps  per-EP "last token was SETUP".
REQ-015 out_ep_oversize_o, out_ep_timeout_o  out  1 each  single-cycle error pulses.
REQ-016 tx_pkt_start_o  out  1; tx_pid_o  out  4  handshake request.

Function
REQ-017 EP implemented iff rx_endp_i < NumOutEps; active iff implemented and out_ep_enable_i bit set.
REQ-018 States: Idle, RcvdOut, RcvdDataStart, RcvdDataEnd, RcvdIsoDataEnd; Idle after reset.
REQ-019 Idle -> RcvdOut on valid OUT token to dev_addr_i (any EP), or SETUP to active EP; SETUP to inactive EP ignored; same cycle pulse out_ep_newpkt_o next cycle, latch EP (0 if unimplemented), setup flag.
REQ-020 OUT token to implemented-but-disabled EP treated as unimplemented (STALL path).
REQ-021 RcvdOut -> RcvdDataStart on rx_pkt_start_i; timer counts every RcvdOut cycle; at RxTimeoutCycles -> Idle, pulse out_ep_timeout_o, no tx.
REQ-022 RcvdDataStart priority: ISO data end -> RcvdIsoDataEnd; wrong toggle on non-stalled active EP -> Idle, rollback, ACK; oversize -> Idle, rollback, out_ep_oversize_o, no tx; invalid/non-DATA end -> Idle, rollback, no tx; valid DATA end -> RcvdDataEnd.
REQ-023 Oversize: byte counter reaches MaxOutPktSizeByte and another rx_data_put_i arrives; excess bytes never written.
REQ-024 RcvdDataEnd (1 cycle) -> Idle with tx_pkt_start_o: STALL if (inactive or stalled) and not SETUP; else NAK+rollback if nak latched; else ACK, acked, toggle flips.
REQ-025 RcvdIsoDataEnd -> Idle: STALL only if stalled and not SETUP; nak -> rollback, no tx; else acked, no tx, toggle unchanged.
REQ-026 out_ep_data_put_o = registered (RcvdDataStart && rx_data_put_i); out_ep_data_o registers rx_data_i on every put.
REQ-027 nak latch clears in Idle/RcvdOut; sets on data_put while current EP full; sticky for transfer.
REQ-028 Put address zeroes in RcvdOut; increments per put unless nak or saturated at all-ones.
REQ-029 Toggle update priority: SETUP clear > ACK flip; then clear mask, then set mask (set wins over clear, same cycle).
REQ-030 out_ep_setup_o bit set on SETUP, cleared on OUT, to that active EP.
REQ-031 link_reset_i mid-transfer: next cycle Idle, no tx, no acked; pending rollback not issued.

Reset
REQ-032 rst_i high at clock edge: state Idle, all outputs 0, toggles 0, counters 0, out_ep_setup_o 0; applies whatever state.

Verification
REQ-033 SETUP EP0, DATA0 8 bytes, not full -> put_addr 0..7, ACK (0x2), acked 1 cycle, toggle[0]=1.
REQ-034 OUT EP3 with full[3]=1, DATA0 4 bytes -> nak latched, tx_pid 0xA, rollback pulse, toggle unchanged.
REQ-035 OUT EP15 with NumOutEps=12 -> DATA end -> tx_pid STALL (0xE), out_ep_current_o=0.
REQ-036 OUT EP1, no DATA for 80 cycles -> out_ep_timeout_o pulse, Idle, no tx_pkt_start_o.
REQ-037 MaxOutPktSizeByte=8, DATA 9 bytes -> out_ep_oversize_o, rollback, 8 puts only, no tx.
REQ-038 ISO EP2, DATA1 after DATA0 -> acked each time, no tx, toggle[2] unchanged.

Source files
------------

// File: rtl/usb_fs_out_pe_mc.sv
// USB full-speed OUT/SETUP protocol engine: accepts OUT/SETUP tokens, streams the DATA
// payload into the endpoint buffer write port and answers with ACK, NAK or STALL.
`timescale 1ns/1ps
module usb_fs_out_pe_mc #(
    parameter int unsigned NumOutEps         = 12,
    parameter int unsigned MaxOutPktSizeByte = 64,
    parameter int unsigned RxTimeoutCycles   = 80,
    localparam int unsigned PktW             = $clog2(MaxOutPktSizeByte)
) (
    input  logic                 clk_48mhz_i,
    input  logic                 rst_i,
    input  logic                 link_reset_i,
    input  logic [6:0]           dev_addr_i,
    input  logic                 rx_pkt_start_i,
    input  logic                 rx_pkt_end_i,
    input  logic                 rx_pkt_valid_i,
    input  logic [3:0]           rx_pid_i,
    input  logic [6:0]           rx_addr_i,
    input  logic [3:0]           rx_endp_i,
    input  logic                 rx_data_put_i,
    input  logic [7:0]           rx_data_i,
    input  logic [NumOutEps-1:0] out_ep_enable_i,
    input  logic [NumOutEps-1:0] out_ep_full_i,
    input  logic [NumOutEps-1:0] out_ep_stall_i,
    input  logic [NumOutEps-1:0] out_ep_iso_i,
    input  logic [NumOutEps-1:0] data_toggle_clear_i,
    input  logic [NumOutEps-1:0] data_toggle_set_i,
    output logic [3:0]           out_ep_current_o,
    output logic                 out_ep_data_put_o,
    output logic [PktW-1:0]      out_ep_put_addr_o,
    output logic [7:0]           out_ep_data_o,
    output logic                 out_ep_newpkt_o,
    output logic                 out_ep_acked_o,
    output logic                 out_ep_rollback_o,
    output logic [NumOutEps-1:0] out_ep_setup_o,
    output logic                 out_ep_oversize_o,
    output logic                 out_ep_timeout_o,
    output logic                 tx_pkt_start_o,
    output logic [3:0]           tx_pid_o,
    output logic [2:0]           out_xfr_state_o
);

    typedef enum logic [2:0] {
        StIdle           = 3'd0,
        StRcvdOut        = 3'd1,
        StRcvdDataStart  = 3'd2,
        StRcvdDataEnd    = 3'd3,
        StRcvdIsoDataEnd = 3'd4
    } state_e;

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;

    localparam logic [PktW:0] MaxCnt      = MaxOutPktSizeByte[PktW:0];
    localparam logic [7:0]    TimeoutLast = 8'(RxTimeoutCycles - 1);

    state_e               state_q;
    logic [3:0]           cur_ep_q;
    logic                 cur_active_q;
    logic                 cur_setup_q;
    logic                 nak_q;
    logic [7:0]           timer_q;
    logic [PktW:0]        byte_cnt_q;
    logic [NumOutEps-1:0] data_toggle_q;
    logic [NumOutEps-1:0] toggle_d;
    logic [NumOutEps-1:0] setup_d;

    // Per-EP vectors widened to 16 so any 4-bit endpoint number can index them.
    logic [15:0] enable_ext, full_ext, stall_ext, iso_ext, toggle_ext;
    assign enable_ext = 16'(out_ep_enable_i);
    assign full_ext   = 16'(out_ep_full_i);
    assign stall_ext  = 16'(out_ep_stall_i);
    assign iso_ext    = 16'(out_ep_iso_i);
    assign toggle_ext = 16'(data_toggle_q);

    logic rx_ep_active, token_ok, accept_tok, accept_setup;
    assign rx_ep_active = ({1'b0, rx_endp_i} < 5'(NumOutEps)) && enable_ext[rx_endp_i];
    assign token_ok     = rx_pkt_end_i && rx_pkt_valid_i && (rx_addr_i == dev_addr_i);
    assign accept_tok   = (state_q == StIdle) && token_ok &&
                          ((rx_pid_i == PidOut) || (rx_pid_i == PidSetup && rx_ep_active));
    assign accept_setup = accept_tok && (rx_pid_i == PidSetup);

    logic cur_stalled, cur_full, cur_iso, stall_cond, rx_is_data, bad_toggle, at_max, ack_flip;
    assign cur_stalled = stall_ext[cur_ep_q];
    assign cur_full    = full_ext[cur_ep_q];
    assign cur_iso     = iso_ext[cur_ep_q] && cur_active_q;
    assign stall_cond  = (!cur_active_q || cur_stalled) && !cur_setup_q;
    assign rx_is_data  = (rx_pid_i == PidData0) || (rx_pid_i == PidData1);
    assign bad_toggle  = rx_pid_i[3] != toggle_ext[cur_ep_q];
    assign at_max      = byte_cnt_q == MaxCnt;
    assign ack_flip    = (state_q == StRcvdDataEnd) && !stall_cond && !nak_q;

    // SETUP clear beats ACK flip; software clear then set masks apply last, set winning.
    always_comb begin
        toggle_d = data_toggle_q;
        for (int unsigned i = 0; i < NumOutEps; i++) begin
            if (accept_setup && rx_endp_i == 4'(i)) begin
                toggle_d[i] = 1'b0;
            end else if (ack_flip && cur_ep_q == 4'(i)) begin
                toggle_d[i] = ~data_toggle_q[i];
            end
        end
        toggle_d = (toggle_d & ~data_toggle_clear_i) | data_toggle_set_i;
    end

    always_comb begin
        setup_d = out_ep_setup_o;
        for (int unsigned i = 0; i < NumOutEps; i++) begin
            if (accept_tok && rx_ep_active && rx_endp_i == 4'(i)) begin
                setup_d[i] = (rx_pid_i == PidSetup);
            end
        end
    end

    assign out_xfr_state_o  = state_q;
    assign out_ep_current_o = cur_ep_q;

    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i || link_reset_i) begin
            state_q           <= StIdle;
            cur_ep_q          <= 4'd0;
            cur_active_q      <= 1'b0;
            cur_setup_q       <= 1'b0;
            nak_q             <= 1'b0;
            timer_q           <= 8'd0;
            byte_cnt_q        <= '0;
            data_toggle_q     <= '0;
            out_ep_setup_o    <= '0;
            out_ep_data_put_o <= 1'b0;
            out_ep_put_addr_o <= '0;
            out_ep_data_o     <= 8'd0;
            out_ep_newpkt_o   <= 1'b0;
            out_ep_acked_o    <= 1'b0;
            out_ep_rollback_o <= 1'b0;
            out_ep_oversize_o <= 1'b0;
            out_ep_timeout_o  <= 1'b0;
            tx_pkt_start_o    <= 1'b0;
            tx_pid_o          <= 4'd0;
        end else begin
            out_ep_newpkt_o   <= 1'b0;
            out_ep_acked_o    <= 1'b0;
            out_ep_rollback_o <= 1'b0;
            out_ep_oversize_o <= 1'b0;
            out_ep_timeout_o  <= 1'b0;
            tx_pkt_start_o    <= 1'b0;
            tx_pid_o          <= 4'd0;
            data_toggle_q     <= toggle_d;
            out_ep_setup_o    <= setup_d;
            // The byte that would overflow the buffer is never presented on the write port.
            out_ep_data_put_o <= (state_q == StRcvdDataStart) && rx_data_put_i && !at_max;
            if (rx_data_put_i) begin
                out_ep_data_o <= rx_data_i;
            end

            if (state_q == StRcvdOut) begin
                out_ep_put_addr_o <= '0;
            end else if (out_ep_data_put_o && !nak_q && !(&out_ep_put_addr_o)) begin
                out_ep_put_addr_o <= out_ep_put_addr_o + 1'b1;
            end

            if (state_q == StIdle || state_q == StRcvdOut) begin
                nak_q <= 1'b0;
            end else if (state_q == StRcvdDataStart && rx_data_put_i && cur_full) begin
                nak_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    timer_q    <= 8'd0;
                    byte_cnt_q <= '0;
                    if (accept_tok) begin
                        state_q         <= StRcvdOut;
                        out_ep_newpkt_o <= 1'b1;
                        cur_ep_q        <= rx_ep_active ? rx_endp_i : 4'd0;
                        cur_active_q    <= rx_ep_active;
                        cur_setup_q     <= (rx_pid_i == PidSetup);
                    end
                end
                StRcvdOut: begin
                    byte_cnt_q <= '0;
                    if (rx_pkt_start_i) begin
                        state_q <= StRcvdDataStart;
                    end else if (timer_q == TimeoutLast) begin
                        state_q          <= StIdle;
                        out_ep_timeout_o <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StRcvdDataStart: begin
                    if (rx_data_put_i && !at_max) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                    if (rx_pkt_end_i && cur_iso) begin
                        state_q <= StRcvdIsoDataEnd;
                    end else if (rx_pkt_end_i && rx_pkt_valid_i && rx_is_data && bad_toggle &&
                                 cur_active_q && !cur_stalled) begin
                        // Retransmission of a packet we already took: ACK it, drop the copy.
                        state_q           <= StIdle;
                        out_ep_rollback_o <= 1'b1;
                        tx_pkt_start_o    <= 1'b1;
                        tx_pid_o          <= PidAck;
                    end else if (rx_data_put_i && at_max) begin
                        state_q           <= StIdle;
                        out_ep_rollback_o <= 1'b1;
                        out_ep_oversize_o <= 1'b1;
                    end else if (rx_pkt_end_i && !(rx_pkt_valid_i && rx_is_data)) begin
                        state_q           <= StIdle;
                        out_ep_rollback_o <= 1'b1;
                    end else if (rx_pkt_end_i) begin
                        state_q <= StRcvdDataEnd;
                    end
                end
                StRcvdDataEnd: begin
                    state_q        <= StIdle;
                    tx_pkt_start_o <= 1'b1;
                    if (stall_cond) begin
                        tx_pid_o <= PidStall;
                    end else if (nak_q) begin
                        tx_pid_o          <= PidNak;
                        out_ep_rollback_o <= 1'b1;
                    end else begin
                        tx_pid_o       <= PidAck;
                        out_ep_acked_o <= 1'b1;
                    end
                end
                StRcvdIsoDataEnd: begin
                    state_q <= StIdle;
                    if (cur_stalled && !cur_setup_q) begin
                        tx_pkt_start_o <= 1'b1;
                        tx_pid_o       <= PidStall;
                    end else if (nak_q) begin
                        out_ep_rollback_o <= 1'b1;
                    end else begin
                        out_ep_acked_o <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fs_out_pe_mc.sv
// Directed bench for usb_fs_out_pe_mc: a 64-byte instance plus an 8-byte instance for
// the oversize case, both fed from the same bus stimulus.
`timescale 1ns/1ps
module tb_usb_fs_out_pe_mc;

    localparam logic [3:0] PidOut = 4'h1, PidSetup = 4'hD, PidData0 = 4'h3, PidData1 = 4'hB;
    localparam logic [6:0] DevAddr = 7'h2A;

    logic        clk_48mhz_i = 1'b0;
    logic        rst_i = 1'b1, link_reset_i = 1'b0;
    logic [6:0]  dev_addr_i = DevAddr;
    logic        rx_pkt_start_i = 1'b0, rx_pkt_end_i = 1'b0, rx_pkt_valid_i = 1'b0;
    logic [3:0]  rx_pid_i = 4'h0, rx_endp_i = 4'h0;
    logic [6:0]  rx_addr_i = 7'h0;
    logic        rx_data_put_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h0;
    logic [11:0] out_ep_enable_i = 12'hFFF, out_ep_full_i = '0, out_ep_stall_i = '0;
    logic [11:0] out_ep_iso_i = '0, data_toggle_clear_i = '0, data_toggle_set_i = '0;

    logic [3:0]  out_ep_current_o, tx_pid_o;
    logic        out_ep_data_put_o, out_ep_newpkt_o, out_ep_acked_o, out_ep_rollback_o;
    logic [5:0]  out_ep_put_addr_o;
    logic [7:0]  out_ep_data_o;
    logic [11:0] out_ep_setup_o;
    logic        out_ep_oversize_o, out_ep_timeout_o, tx_pkt_start_o;
    logic [2:0]  out_xfr_state_o;

    logic [3:0]  cur_8, tx_pid_8;
    logic        put_8, newpkt_8, acked_8, rollback_8, oversize_8, timeout_8, tx_start_8;
    logic [2:0]  put_addr_8, state_8;
    logic [7:0]  data_8;
    logic [11:0] setup_8;

    int checks = 0;
    int errors = 0;

    usb_fs_out_pe_mc dut (
        .clk_48mhz_i(clk_48mhz_i), .rst_i(rst_i), .link_reset_i(link_reset_i), .dev_addr_i(dev_addr_i),
        .rx_pkt_start_i(rx_pkt_start_i), .rx_pkt_end_i(rx_pkt_end_i), .rx_pkt_valid_i(rx_pkt_valid_i),
        .rx_pid_i(rx_pid_i), .rx_addr_i(rx_addr_i), .rx_endp_i(rx_endp_i),
        .rx_data_put_i(rx_data_put_i), .rx_data_i(rx_data_i),
        .out_ep_enable_i(out_ep_enable_i), .out_ep_full_i(out_ep_full_i), .out_ep_stall_i(out_ep_stall_i),
        .out_ep_iso_i(out_ep_iso_i), .data_toggle_clear_i(data_toggle_clear_i), .data_toggle_set_i(data_toggle_set_i),
        .out_ep_current_o(out_ep_current_o), .out_ep_data_put_o(out_ep_data_put_o),
        .out_ep_put_addr_o(out_ep_put_addr_o), .out_ep_data_o(out_ep_data_o),
        .out_ep_newpkt_o(out_ep_newpkt_o), .out_ep_acked_o(out_ep_acked_o), .out_ep_rollback_o(out_ep_rollback_o),
        .out_ep_setup_o(out_ep_setup_o), .out_ep_oversize_o(out_ep_oversize_o), .out_ep_timeout_o(out_ep_timeout_o),
        .tx_pkt_start_o(tx_pkt_start_o), .tx_pid_o(tx_pid_o), .out_xfr_state_o(out_xfr_state_o)
    );

    usb_fs_out_pe_mc #(.NumOutEps(12), .MaxOutPktSizeByte(8), .RxTimeoutCycles(80)) dut8 (
        .clk_48mhz_i(clk_48mhz_i), .rst_i(rst_i), .link_reset_i(link_reset_i), .dev_addr_i(dev_addr_i),
        .rx_pkt_start_i(rx_pkt_start_i), .rx_pkt_end_i(rx_pkt_end_i), .rx_pkt_valid_i(rx_pkt_valid_i),
        .rx_pid_i(rx_pid_i), .rx_addr_i(rx_addr_i), .rx_endp_i(rx_endp_i),
        .rx_data_put_i(rx_data_put_i), .rx_data_i(rx_data_i),
        .out_ep_enable_i(out_ep_enable_i), .out_ep_full_i(out_ep_full_i), .out_ep_stall_i(out_ep_stall_i),
        .out_ep_iso_i(out_ep_iso_i), .data_toggle_clear_i(data_toggle_clear_i), .data_toggle_set_i(data_toggle_set_i),
        .out_ep_current_o(cur_8), .out_ep_data_put_o(put_8), .out_ep_put_addr_o(put_addr_8),
        .out_ep_data_o(data_8), .out_ep_newpkt_o(newpkt_8), .out_ep_acked_o(acked_8),
        .out_ep_rollback_o(rollback_8), .out_ep_setup_o(setup_8), .out_ep_oversize_o(oversize_8),
        .out_ep_timeout_o(timeout_8), .tx_pkt_start_o(tx_start_8), .tx_pid_o(tx_pid_8),
        .out_xfr_state_o(state_8)
    );

    // Clock and watchdog
    always #10 clk_48mhz_i = ~clk_48mhz_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Pulse monitor, sampled on the falling edge; counters are cumulative.
    int n_put = 0, n_put8 = 0, n_ack = 0, n_rb = 0, n_rb8 = 0, n_ovs8 = 0, n_tx = 0, n_tx8 = 0, n_to = 0;
    logic [3:0] last_pid = 4'h0;
    logic [5:0] addr_log [0:255];
    logic [7:0] data_log [0:255];
    logic [2:0] addr8_log [0:255];

    always @(negedge clk_48mhz_i) begin
        if (out_ep_data_put_o) begin
            addr_log[8'(n_put)] <= out_ep_put_addr_o;
            data_log[8'(n_put)] <= out_ep_data_o;
            n_put <= n_put + 1;
        end
        if (put_8) begin
            addr8_log[8'(n_put8)] <= put_addr_8;
            n_put8 <= n_put8 + 1;
        end
        if (out_ep_acked_o)    n_ack <= n_ack + 1;
        if (out_ep_rollback_o) n_rb <= n_rb + 1;
        if (rollback_8)        n_rb8 <= n_rb8 + 1;
        if (oversize_8)        n_ovs8 <= n_ovs8 + 1;
        if (out_ep_timeout_o)  n_to <= n_to + 1;
        if (tx_start_8)        n_tx8 <= n_tx8 + 1;
        if (tx_pkt_start_o) begin
            n_tx <= n_tx + 1;
            last_pid <= tx_pid_o;
        end
    end

    // Driver tasks: inputs change 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk_48mhz_i);
        #1;
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [3:0] endp);
        rx_pkt_start_i = 1'b1; cyc(); rx_pkt_start_i = 1'b0; cyc();
        rx_pkt_end_i = 1'b1; rx_pkt_valid_i = 1'b1; rx_pid_i = pid; rx_addr_i = DevAddr; rx_endp_i = endp;
        cyc();
        rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0;
    endtask

    task automatic send_data(input logic [3:0] pid, input int nbytes);
        rx_pkt_start_i = 1'b1; cyc(); rx_pkt_start_i = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            rx_data_put_i = 1'b1; rx_data_i = 8'(16 + i); cyc();
        end
        rx_data_put_i = 1'b0;
        rx_pkt_end_i = 1'b1; rx_pkt_valid_i = 1'b1; rx_pid_i = pid; cyc();
        rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0;
        cyc(); cyc();
    endtask

    // Scenarios
    task automatic test_reset();
        rst_i = 1'b1; cyc(); cyc(); rst_i = 1'b0; cyc();
        checks++; if (out_xfr_state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", out_xfr_state_o); end
        checks++; if ({tx_pkt_start_o, tx_pid_o, out_ep_data_put_o, out_ep_put_addr_o, out_ep_current_o} !== 16'h0) begin
            errors++; $display("FAIL reset_outputs: got tx=%b pid=%h put=%b addr=%0d cur=%0d expected all 0",
                               tx_pkt_start_o, tx_pid_o, out_ep_data_put_o, out_ep_put_addr_o, out_ep_current_o); end
        checks++; if (out_ep_setup_o !== 12'h0) begin errors++; $display("FAIL reset_setup: got %h expected 000", out_ep_setup_o); end
        send_token(PidOut, 4'd1);
        checks++; if (out_xfr_state_o !== 3'd1 || out_ep_current_o !== 4'd1) begin
            errors++; $display("FAIL token_out_ep1: got state=%0d cur=%0d expected state=1 cur=1", out_xfr_state_o, out_ep_current_o); end
        rst_i = 1'b1; cyc(); rst_i = 1'b0;
        checks++; if (out_xfr_state_o !== 3'd0 || out_ep_current_o !== 4'd0) begin
            errors++; $display("FAIL reset_midxfer: got state=%0d cur=%0d expected 0 0", out_xfr_state_o, out_ep_current_o); end
    endtask

    task automatic test_setup_ack();
        int p0, t0, a0, r0;
        logic bad_addr;
        p0 = n_put; t0 = n_tx; a0 = n_ack; r0 = n_rb; bad_addr = 1'b0;
        send_token(PidSetup, 4'd0);
        checks++; if (out_ep_newpkt_o !== 1'b1 || out_ep_setup_o[0] !== 1'b1) begin
            errors++; $display("FAIL setup_newpkt: got newpkt=%b setup0=%b expected 1 1", out_ep_newpkt_o, out_ep_setup_o[0]); end
        send_data(PidData0, 8);
        checks++; if (n_put - p0 != 8) begin errors++; $display("FAIL setup_puts: got %0d expected 8", n_put - p0); end
        for (int k = 0; k < 8; k++) begin
            if (addr_log[8'(p0 + k)] !== 6'(k) || data_log[8'(p0 + k)] !== 8'(16 + k)) bad_addr = 1'b1;
        end
        checks++; if (bad_addr) begin errors++; $display("FAIL setup_addr_seq: got out-of-order addr/data expected addr 0..7 data 10..17"); end
        checks++; if (n_tx - t0 != 1 || last_pid !== 4'h2) begin
            errors++; $display("FAIL setup_ack: got tx=%0d pid=%h expected 1 2", n_tx - t0, last_pid); end
        checks++; if (n_ack - a0 != 1 || n_rb - r0 != 0) begin
            errors++; $display("FAIL setup_acked: got acked=%0d rollback=%0d expected 1 0", n_ack - a0, n_rb - r0); end
        checks++; if (dut.data_toggle_q[0] !== 1'b1) begin errors++; $display("FAIL setup_toggle0: got %b expected 1", dut.data_toggle_q[0]); end
    endtask

    task automatic test_bad_toggle();
        int t0, a0, r0;
        t0 = n_tx; a0 = n_ack; r0 = n_rb;
        send_token(PidOut, 4'd0);
        checks++; if (out_ep_setup_o[0] !== 1'b0) begin errors++; $display("FAIL out_clears_setup: got %b expected 0", out_ep_setup_o[0]); end
        send_data(PidData0, 2);
        checks++; if (n_tx - t0 != 1 || last_pid !== 4'h2 || n_rb - r0 != 1 || n_ack - a0 != 0) begin
            errors++; $display("FAIL bad_toggle: got tx=%0d pid=%h rollback=%0d acked=%0d expected 1 2 1 0",
                               n_tx - t0, last_pid, n_rb - r0, n_ack - a0); end
        checks++; if (dut.data_toggle_q[0] !== 1'b1) begin errors++; $display("FAIL bad_toggle_keep: got %b expected 1", dut.data_toggle_q[0]); end
    endtask

    task automatic test_nak();
        int p0, t0, a0, r0;
        p0 = n_put; t0 = n_tx; a0 = n_ack; r0 = n_rb;
        out_ep_full_i = 12'h008;
        send_token(PidOut, 4'd3);
        send_data(PidData0, 4);
        out_ep_full_i = 12'h000;
        checks++; if (n_tx - t0 != 1 || last_pid !== 4'hA) begin errors++; $display("FAIL nak_pid: got tx=%0d pid=%h expected 1 a", n_tx - t0, last_pid); end
        checks++; if (n_rb - r0 != 1 || n_ack - a0 != 0) begin
            errors++; $display("FAIL nak_rollback: got rollback=%0d acked=%0d expected 1 0", n_rb - r0, n_ack - a0); end
        checks++; if (n_put - p0 != 4 || addr_log[8'(p0 + 3)] !== 6'd0) begin
            errors++; $display("FAIL nak_addr_hold: got puts=%0d last addr=%0d expected 4 0", n_put - p0, addr_log[8'(p0 + 3)]); end
        checks++; if (dut.data_toggle_q[3] !== 1'b0) begin errors++; $display("FAIL nak_toggle3: got %b expected 0", dut.data_toggle_q[3]); end
    endtask

    task automatic test_stall();
        int t0, a0;
        t0 = n_tx; a0 = n_ack;
        send_token(PidOut, 4'd15);
        checks++; if (out_ep_current_o !== 4'd0 || out_xfr_state_o !== 3'd1) begin
            errors++; $display("FAIL unimpl_current: got cur=%0d state=%0d expected 0 1", out_ep_current_o, out_xfr_state_o); end
        send_data(PidData0, 2);
        checks++; if (n_tx - t0 != 1 || last_pid !== 4'hE || n_ack - a0 != 0) begin
            errors++; $display("FAIL unimpl_stall: got tx=%0d pid=%h acked=%0d expected 1 e 0", n_tx - t0, last_pid, n_ack - a0); end
        out_ep_enable_i = 12'hFDF;
        send_token(PidSetup, 4'd5);
        checks++; if (out_xfr_state_o !== 3'd0 || out_ep_newpkt_o !== 1'b0) begin
            errors++; $display("FAIL setup_disabled_ignored: got state=%0d newpkt=%b expected 0 0", out_xfr_state_o, out_ep_newpkt_o); end
        send_token(PidOut, 4'd5);
        send_data(PidData0, 1);
        out_ep_enable_i = 12'hFFF;
        checks++; if (n_tx - t0 != 2 || last_pid !== 4'hE) begin
            errors++; $display("FAIL disabled_stall: got tx=%0d pid=%h expected 2 e", n_tx - t0, last_pid); end
    endtask

    task automatic test_timeout();
        int t0, o0, n;
        t0 = n_tx; o0 = n_to; n = 0;
        send_token(PidOut, 4'd1);
        while (n < 200 && out_ep_timeout_o !== 1'b1) begin
            cyc(); n++;
        end
        checks++; if (n != 80) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 80", n); end
        cyc();
        checks++; if (out_xfr_state_o !== 3'd0 || n_tx - t0 != 0 || n_to - o0 != 1) begin
            errors++; $display("FAIL timeout_idle: got state=%0d tx=%0d pulses=%0d expected 0 0 1", out_xfr_state_o, n_tx - t0, n_to - o0); end
    endtask

    task automatic test_oversize();
        int p0, t0, r0, v0;
        p0 = n_put8; t0 = n_tx8; r0 = n_rb8; v0 = n_ovs8;
        send_token(PidOut, 4'd4);
        send_data(PidData0, 9);
        checks++; if (n_ovs8 - v0 != 1 || n_rb8 - r0 != 1) begin
            errors++; $display("FAIL oversize_pulse: got oversize=%0d rollback=%0d expected 1 1", n_ovs8 - v0, n_rb8 - r0); end
        checks++; if (n_put8 - p0 != 8 || addr8_log[8'(p0 + 7)] !== 3'd7) begin
            errors++; $display("FAIL oversize_puts: got puts=%0d last addr=%0d expected 8 7", n_put8 - p0, addr8_log[8'(p0 + 7)]); end
        checks++; if (n_tx8 - t0 != 0 || state_8 !== 3'd0) begin
            errors++; $display("FAIL oversize_notx: got tx=%0d state=%0d expected 0 0", n_tx8 - t0, state_8); end
    endtask

    task automatic test_iso();
        int t0, a0;
        t0 = n_tx; a0 = n_ack;
        out_ep_iso_i = 12'h004;
        send_token(PidOut, 4'd2);
        send_data(PidData0, 3);
        checks++; if (n_ack - a0 != 1 || n_tx - t0 != 0) begin
            errors++; $display("FAIL iso_first: got acked=%0d tx=%0d expected 1 0", n_ack - a0, n_tx - t0); end
        send_token(PidOut, 4'd2);
        send_data(PidData1, 3);
        out_ep_iso_i = 12'h000;
        checks++; if (n_ack - a0 != 2 || n_tx - t0 != 0) begin
            errors++; $display("FAIL iso_second: got acked=%0d tx=%0d expected 2 0", n_ack - a0, n_tx - t0); end
        checks++; if (dut.data_toggle_q[2] !== 1'b0) begin errors++; $display("FAIL iso_toggle2: got %b expected 0", dut.data_toggle_q[2]); end
    endtask

    task automatic test_toggle_masks();
        data_toggle_set_i = 12'h040; data_toggle_clear_i = 12'h041; cyc();
        data_toggle_set_i = 12'h000; data_toggle_clear_i = 12'h000; cyc();
        checks++; if (dut.data_toggle_q[6] !== 1'b1 || dut.data_toggle_q[0] !== 1'b0) begin
            errors++; $display("FAIL toggle_set_wins: got t6=%b t0=%b expected 1 0", dut.data_toggle_q[6], dut.data_toggle_q[0]); end
        data_toggle_clear_i = 12'h040; cyc(); data_toggle_clear_i = 12'h000; cyc();
        checks++; if (dut.data_toggle_q[6] !== 1'b0) begin errors++; $display("FAIL toggle_clear: got %b expected 0", dut.data_toggle_q[6]); end
    endtask

    task automatic test_link_reset();
        int t0, a0, r0;
        data_toggle_set_i = 12'h002; cyc(); data_toggle_set_i = 12'h000;
        t0 = n_tx; a0 = n_ack; r0 = n_rb;
        send_token(PidOut, 4'd1);
        rx_pkt_start_i = 1'b1; cyc(); rx_pkt_start_i = 1'b0;
        rx_data_put_i = 1'b1; rx_data_i = 8'h55; cyc(); cyc(); rx_data_put_i = 1'b0;
        link_reset_i = 1'b1; cyc(); link_reset_i = 1'b0;
        checks++; if (out_xfr_state_o !== 3'd0 || dut.data_toggle_q !== 12'h000) begin
            errors++; $display("FAIL link_reset_idle: got state=%0d toggles=%h expected 0 000", out_xfr_state_o, dut.data_toggle_q); end
        rx_pkt_end_i = 1'b1; rx_pkt_valid_i = 1'b1; rx_pid_i = PidData1; cyc();
        rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0; cyc(); cyc();
        checks++; if (n_tx - t0 != 0 || n_ack - a0 != 0 || n_rb - r0 != 0) begin
            errors++; $display("FAIL link_reset_quiet: got tx=%0d acked=%0d rollback=%0d expected 0 0 0", n_tx - t0, n_ack - a0, n_rb - r0); end
    endtask

    initial begin
        test_reset();
        test_setup_ack();
        test_bad_toggle();
        test_nak();
        test_stall();
        test_timeout();
        test_oversize();
        test_iso();
        test_toggle_masks();
        test_link_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
